// File: rtl/snake_pkg.sv
// Shared types and constants for the snake display path: cell codes, RGB565 colours,
// ILI9341 window/write opcodes and the default playfield size.
package snake_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    HEAD   = 3'd1,
    BODY   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_code_t;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StPaset,
    StRamwr,
    StPixel,
    StDone
  } draw_state_t;

  localparam logic [15:0] ColEmpty   = 16'h0000;
  localparam logic [15:0] ColHead    = 16'hFFE0;
  localparam logic [15:0] ColBody    = 16'h07E0;
  localparam logic [15:0] ColApple   = 16'hF800;
  localparam logic [15:0] ColBorder  = 16'h001F;
  localparam logic [15:0] ColInvalid = 16'hF81F;

  localparam logic [7:0] OpCaset = 8'h2A;
  localparam logic [7:0] OpPaset = 8'h2B;
  localparam logic [7:0] OpRamwr = 8'h2C;

  localparam int unsigned GridWDefault = 16;
  localparam int unsigned GridHDefault = 12;

  function automatic logic [15:0] obj_colour(input logic [2:0] code);
    logic [15:0] c;
    case (code)
      EMPTY:   c = ColEmpty;
      HEAD:    c = ColHead;
      BODY:    c = ColBody;
      APPLE:   c = ColApple;
      BORDER:  c = ColBorder;
      default: c = ColInvalid;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// 8080 write-only byte engine: latches dc/byte on req, drives wrx low then high for
// WR_CYCLES each, and pulses ack in the last high cycle so the next byte can follow directly.
module lcd_byte_writer #(
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       dc_i,
  input  logic [7:0] byte_i,
  output logic       ack_o,
  output logic       wrx_o,
  output logic       dcx_o,
  output logic [7:0] data_o
);

  typedef enum logic [1:0] {PhIdle, PhLow, PhHigh} phase_t;

  localparam logic [7:0] CntLast = 8'(WR_CYCLES - 1);

  phase_t     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dc_q, dc_d;
  logic [7:0] data_q, data_d;
  logic       accept;

  assign ack_o  = (phase_q == PhHigh) && (cnt_q == CntLast);
  assign accept = req_i && ((phase_q == PhIdle) || ack_o);
  assign wrx_o  = (phase_q != PhLow);
  assign dcx_o  = dc_q;
  assign data_o = data_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dc_d    = dc_q;
    data_d  = data_q;
    if (accept) begin
      phase_d = PhLow;
      cnt_d   = '0;
      dc_d    = dc_i;
      data_d  = byte_i;
    end else begin
      case (phase_q)
        PhLow: begin
          if (cnt_q == CntLast) begin
            phase_d = PhHigh;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PhHigh: begin
          if (cnt_q == CntLast) begin
            phase_d = PhIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      dc_q    <= 1'b1;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cell_draw_engine.sv
// Paints one 20x20 tile per update request: sets the LCD column/page window, issues RAMWR,
// then streams the cell colour, and pulses cmd_done when the last byte has been written.
module cell_draw_engine
  import snake_pkg::*;
#(
  parameter int unsigned CELL_PX   = 20,
  parameter int unsigned GRID_W    = GridWDefault,
  parameter int unsigned GRID_H    = GridHDefault,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_update,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  localparam logic [8:0] PixLast = 9'(CELL_PX * CELL_PX - 1);
  localparam logic [2:0] WinLast = 3'd4;

  draw_state_t state_q, state_d;
  logic [3:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  obj_q, obj_d, idx_q, idx_d;
  logic [8:0]  pix_q, pix_d;
  logic        oob_q, oob_d, ph_q, ph_d, last_q, last_d, inflight_q, inflight_d;

  logic        wr_req, wr_dc, wr_ack, go;
  logic [7:0]  wr_byte;
  logic [3:0]  coord;
  logic [8:0]  win_lo, win_hi;
  logic [15:0] colour;

  // A new byte may be handed over when nothing is in flight or the current one is finishing.
  assign go     = !inflight_q || wr_ack;
  assign coord  = (state_q == StPaset) ? y_q : x_q;
  assign win_lo = 9'(32'(coord) * CELL_PX);
  assign win_hi = win_lo + 9'(CELL_PX - 1);
  assign colour = obj_colour(obj_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      obj_q      <= '0;
      oob_q      <= 1'b0;
      idx_q      <= '0;
      pix_q      <= '0;
      ph_q       <= 1'b0;
      last_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      obj_q      <= obj_d;
      oob_q      <= oob_d;
      idx_q      <= idx_d;
      pix_q      <= pix_d;
      ph_q       <= ph_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    obj_d      = obj_q;
    oob_d      = oob_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    ph_d       = ph_q;
    last_d     = last_q;
    inflight_d = wr_req ? 1'b1 : (wr_ack ? 1'b0 : inflight_q);
    case (state_q)
      StIdle: begin
        if (en_update) begin
          x_d     = x;
          y_d     = y;
          obj_d   = obj_code;
          oob_d   = (32'(x) >= GRID_W) || (32'(y) >= GRID_H);
          idx_d   = '0;
          pix_d   = '0;
          ph_d    = 1'b0;
          last_d  = 1'b0;
          state_d = StCaset;
        end
      end
      // Out-of-range cells walk through the window states without touching the bus.
      StCaset, StPaset: begin
        if (oob_q) begin
          state_d = (state_q == StCaset) ? StPaset : StDone;
        end else if (go) begin
          if (idx_q == WinLast) begin
            idx_d   = '0;
            state_d = (state_q == StCaset) ? StPaset : StRamwr;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StRamwr: if (go) state_d = StPixel;
      StPixel: begin
        if (last_q) begin
          if (wr_ack) state_d = StDone;
        end else if (go) begin
          ph_d = !ph_q;
          if (ph_q) begin
            if (pix_q == PixLast) last_d = 1'b1;
            else                  pix_d  = pix_q + 9'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_dc   = 1'b1;
    wr_byte = 8'h00;
    case (state_q)
      StCaset, StPaset: begin
        if (!oob_q && go) begin
          wr_req = 1'b1;
          case (idx_q)
            3'd0: begin
              wr_dc   = 1'b0;
              wr_byte = (state_q == StCaset) ? OpCaset : OpPaset;
            end
            3'd1:    wr_byte = {7'd0, win_lo[8]};
            3'd2:    wr_byte = win_lo[7:0];
            3'd3:    wr_byte = {7'd0, win_hi[8]};
            default: wr_byte = win_hi[7:0];
          endcase
        end
      end
      StRamwr: begin
        if (go) begin
          wr_req  = 1'b1;
          wr_dc   = 1'b0;
          wr_byte = OpRamwr;
        end
      end
      StPixel: begin
        if (!last_q && go) begin
          wr_req  = 1'b1;
          wr_byte = ph_q ? colour[7:0] : colour[15:8];
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign cmd_done = (state_q == StDone);
  assign lcd_csx  = !(busy && !oob_q);

  lcd_byte_writer #(
    .WR_CYCLES (WR_CYCLES)
  ) u_writer (
    .clk    (clk),
    .rst    (rst),
    .req_i  (wr_req),
    .dc_i   (wr_dc),
    .byte_i (wr_byte),
    .ack_o  (wr_ack),
    .wrx_o  (lcd_wrx),
    .dcx_o  (lcd_dcx),
    .data_o (lcd_data)
  );

endmodule
